multdiv_issue_arbiter: RTL and testbench

- Shares the single iterative mult/div unit between the top and bottom issue lanes of the dual-issue pipeline.
- Arbitrates requests in program order (top before bottom) and sequences the unit with a start pulse, a ready wait and a timeout.
- Returns one writeback per operation, tagged with its destination register and originating lane.
- Drives per-lane stall while the unit is occupied.

---
 rtl/multdiv_pkg.sv | 27 ++
 rtl/multdiv_wait_timer.sv | 40 ++++
 rtl/multdiv_issue_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_multdiv_issue_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the mult/div issue arbiter.
//   state_e        : arbiter FSM encoding (IDLE, LAUNCH, WAIT, DONE)
//   OP_MULT/OP_DIV : operation select on op_top/op_bot
//   RSTATUS_REG    : destination used for every excepting writeback
//   *_EXC_CODE     : status word written to RSTATUS_REG on exception
package multdiv_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLaunch = 2'd1,
    StWait   = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int unsigned RSTATUS_REG   = 30;
  localparam int unsigned MULT_EXC_CODE = 4;
  localparam int unsigned DIV_EXC_CODE  = 5;

  // Status code reported for an excepting op of the given kind.
  function automatic int unsigned exc_code(input logic op);
    return (op == OP_DIV) ? DIV_EXC_CODE : MULT_EXC_CODE;
  endfunction

endpackage

// File: rtl/multdiv_wait_timer.sv
// Cycle counter bounding how long the arbiter waits for the mult/div unit.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : zero the count (wins over en_i)
//   en_i          : advance the count by one
//   terminal_o    : count has reached MAX_WAIT-1
module multdiv_wait_timer #(
  parameter int unsigned MAX_WAIT = 40
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic terminal_o
);

  localparam int unsigned CntW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign terminal_o = (cnt_q == CntW'(MAX_WAIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !terminal_o) begin
      // Saturate at the terminal value so the count never wraps.
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multdiv_issue_arbiter.sv
// Shares one iterative mult/div unit between the top and bottom issue lanes.
// Grants in program order (top first), pulses the unit's start, waits for
// ready or a timeout, then issues a single tagged writeback.
//
// Ports:
//   clock, reset                 : clock, asynchronous active-low reset
//   req/op/opA/opB/rd_{top,bot}  : lane requests (held until granted)
//   flush                        : kills the in-flight op / blocks a grant
//   grant_{top,bot}              : one-cycle accept pulse (IDLE only)
//   stall_{top,bot}              : req_x & ~grant_x
//   md_ctrl_mult/div             : one-cycle start pulse to the unit
//   md_operandA/B                : latched operands
//   md_result/RDY/exception      : unit response
//   wb_valid/rd/data/lane        : writeback
//   busy                         : FSM not in IDLE
//
// Build option: define MULTDIV_FASTPATH_EN to complete mult-by-zero and
// divide-by-zero directly from IDLE to DONE without starting the unit.
module multdiv_issue_arbiter
  import multdiv_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned MAX_WAIT = 40
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_top,
  input  logic              req_bot,
  input  logic              op_top,
  input  logic              op_bot,
  input  logic [DATA_W-1:0] opA_top,
  input  logic [DATA_W-1:0] opB_top,
  input  logic [DATA_W-1:0] opA_bot,
  input  logic [DATA_W-1:0] opB_bot,
  input  logic [REG_W-1:0]  rd_top,
  input  logic [REG_W-1:0]  rd_bot,
  input  logic              flush,
  output logic              grant_top,
  output logic              grant_bot,
  output logic              stall_top,
  output logic              stall_bot,
  output logic              md_ctrl_mult,
  output logic              md_ctrl_div,
  output logic [DATA_W-1:0] md_operandA,
  output logic [DATA_W-1:0] md_operandB,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_resultRDY,
  input  logic              md_exception,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_lane,
  output logic              busy
);

  state_e              state_q, state_d;
  logic                op_q, op_d;
  logic                lane_q, lane_d;
  logic [REG_W-1:0]    rd_q, rd_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                exc_q, exc_d;
  logic                kill_q, kill_d;

  logic                timer_clear;
  logic                timer_en;
  logic                timer_terminal;

  assign timer_clear = (state_q == StLaunch);
  assign timer_en    = (state_q == StWait);

  multdiv_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk_i      (clock),
    .rst_ni     (reset),
    .clear_i    (timer_clear),
    .en_i       (timer_en),
    .terminal_o (timer_terminal)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    lane_d    = lane_q;
    rd_d      = rd_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    exc_d     = exc_q;
    kill_d    = kill_q;
    grant_top = 1'b0;
    grant_bot = 1'b0;

    case (state_q)
      StIdle: begin
        kill_d = 1'b0;
        if (!flush) begin
          if (req_top) begin
            grant_top = 1'b1;
          end else if (req_bot) begin
            grant_bot = 1'b1;
          end
        end
        if (grant_top || grant_bot) begin
          op_d    = grant_top ? op_top  : op_bot;
          opa_d   = grant_top ? opA_top : opA_bot;
          opb_d   = grant_top ? opB_top : opB_bot;
          rd_d    = grant_top ? rd_top  : rd_bot;
          lane_d  = grant_bot;
          res_d   = '0;
          exc_d   = 1'b0;
          state_d = StLaunch;
`ifdef MULTDIV_FASTPATH_EN
          if ((op_d == OP_MULT) && ((opa_d == '0) || (opb_d == '0))) begin
            state_d = StDone;
          end else if ((op_d == OP_DIV) && (opb_d == '0)) begin
            exc_d   = 1'b1;
            state_d = StDone;
          end
`endif
        end
      end

      StLaunch: begin
        // Unit response is not sampled here; the start pulse is going out.
        kill_d  = kill_q | flush;
        state_d = StWait;
      end

      StWait: begin
        kill_d = kill_q | flush;
        if (md_resultRDY) begin
          res_d   = md_result;
          exc_d   = md_exception;
          state_d = StDone;
        end else if (timer_terminal) begin
          exc_d   = 1'b1;
          state_d = StDone;
        end
      end

      StDone: begin
        // A flush here has nothing left to kill: the flag clears on the way
        // back to IDLE.
        kill_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      op_q    <= 1'b0;
      lane_q  <= 1'b0;
      rd_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lane_q  <= lane_d;
      rd_q    <= rd_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      kill_q  <= kill_d;
    end
  end

  always_comb begin
    stall_top    = req_top & ~grant_top;
    stall_bot    = req_bot & ~grant_bot;
    busy         = (state_q != StIdle);
    md_ctrl_mult = (state_q == StLaunch) && (op_q == OP_MULT);
    md_ctrl_div  = (state_q == StLaunch) && (op_q == OP_DIV);
    md_operandA  = opa_q;
    md_operandB  = opb_q;
    wb_valid     = (state_q == StDone) && !kill_q;
    wb_lane      = lane_q;
    wb_rd        = exc_q ? REG_W'(RSTATUS_REG) : rd_q;
    wb_data      = exc_q ? DATA_W'(exc_code(op_q)) : res_q;
  end

endmodule

// File: tb/tb_multdiv_issue_arbiter.sv
// Directed self-checking bench for multdiv_issue_arbiter. Inputs change one
// time unit after the rising edge; outputs are sampled one unit later.
module tb_multdiv_issue_arbiter;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned MAX_WAIT = 40;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_top, req_bot, op_top, op_bot;
  logic [DATA_W-1:0] opA_top, opB_top, opA_bot, opB_bot;
  logic [REG_W-1:0]  rd_top, rd_bot;
  logic              flush;
  logic              grant_top, grant_bot, stall_top, stall_bot;
  logic              md_ctrl_mult, md_ctrl_div;
  logic [DATA_W-1:0] md_operandA, md_operandB;
  logic [DATA_W-1:0] md_result;
  logic              md_resultRDY, md_exception;
  logic              wb_valid;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_lane;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  multdiv_issue_arbiter #(
    .DATA_W   (DATA_W),
    .REG_W    (REG_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_top      (req_top),
    .req_bot      (req_bot),
    .op_top       (op_top),
    .op_bot       (op_bot),
    .opA_top      (opA_top),
    .opB_top      (opB_top),
    .opA_bot      (opA_bot),
    .opB_bot      (opB_bot),
    .rd_top       (rd_top),
    .rd_bot       (rd_bot),
    .flush        (flush),
    .grant_top    (grant_top),
    .grant_bot    (grant_bot),
    .stall_top    (stall_top),
    .stall_bot    (stall_bot),
    .md_ctrl_mult (md_ctrl_mult),
    .md_ctrl_div  (md_ctrl_div),
    .md_operandA  (md_operandA),
    .md_operandB  (md_operandB),
    .md_result    (md_result),
    .md_resultRDY (md_resultRDY),
    .md_exception (md_exception),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_lane      (wb_lane),
    .busy         (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one op from a lane and follow it to writeback. rdy_dly is the
  // number of cycles from the start pulse to md_resultRDY; 0 means never.
  task automatic run_op(input logic lane, input logic op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int rdy_dly,
                        input logic [31:0] res, input logic exc,
                        input logic [4:0] exp_rd, input logic [31:0] exp_data);
    if (lane) begin
      req_bot = 1'b1; op_bot = op; opA_bot = a; opB_bot = b; rd_bot = rd;
    end else begin
      req_top = 1'b1; op_top = op; opA_top = a; opB_top = b; rd_top = rd;
    end
    #1;
    check_eq("grant", lane ? grant_bot : grant_top, 1);
    step();
    req_top = 1'b0;
    req_bot = 1'b0;
    #1;
    check_eq("start_pulse", op ? md_ctrl_div : md_ctrl_mult, 1);
    check_eq("operandA", md_operandA, a);
    check_eq("operandB", md_operandB, b);
    step();
    #1;
    check_eq("pulse_one_cycle", md_ctrl_mult | md_ctrl_div, 0);
    if (rdy_dly > 0) begin
      for (int k = 1; k < rdy_dly; k++) step();
      md_resultRDY = 1'b1;
      md_result    = res;
      md_exception = exc;
    end else begin
      for (int k = 1; k < MAX_WAIT; k++) step();
      #1;
      check_eq("timeout_last_wait_busy", busy, 1);
      check_eq("timeout_last_wait_nowb", wb_valid, 0);
    end
    step();
    md_resultRDY = 1'b0;
    md_exception = 1'b0;
    md_result    = 32'hdead_beef;
    #1;
    check_eq("wb_valid", wb_valid, 1);
    check_eq("wb_rd", wb_rd, exp_rd);
    check_eq("wb_data", wb_data, exp_data);
    check_eq("wb_lane", wb_lane, lane);
    step();
    #1;
    check_eq("idle_busy", busy, 0);
    check_eq("idle_wb_valid", wb_valid, 0);
  endtask

  initial begin
    reset = 1'b0;
    req_top = 0; req_bot = 0; op_top = 0; op_bot = 0;
    opA_top = 0; opB_top = 0; opA_bot = 0; opB_bot = 0;
    rd_top = 0; rd_bot = 0; flush = 0;
    md_result = 0; md_resultRDY = 0; md_exception = 0;

    // Reset state
    step();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_wb_valid", wb_valid, 0);
    check_eq("rst_ctrl", {md_ctrl_mult, md_ctrl_div}, 0);
    check_eq("rst_operandA", md_operandA, 0);
    check_eq("rst_wb_rd", wb_rd, 0);
    reset = 1'b1;
    step();

    // mult 6*7 -> r3, ready 5 cycles after start
    run_op(1'b0, 1'b0, 32'd6, 32'd7, 5'd3, 5, 32'd42, 1'b0, 5'd3, 32'd42);

    // Both lanes request: top first, bottom stalls until IDLE
    req_top = 1; op_top = 0; opA_top = 3;  opB_top = 5; rd_top = 7;
    req_bot = 1; op_bot = 1; opA_bot = 20; opB_bot = 4; rd_bot = 9;
    #1;
    check_eq("both_grant_top", grant_top, 1);
    check_eq("both_grant_bot", grant_bot, 0);
    check_eq("both_stall_bot", stall_bot, 1);
    check_eq("both_stall_top", stall_top, 0);
    step();
    req_top = 0;
    #1;
    check_eq("launch_stall_bot", stall_bot, 1);
    check_eq("launch_mult", md_ctrl_mult, 1);
    step();
    md_resultRDY = 1; md_result = 32'd15;
    #1;
    check_eq("wait_stall_bot", stall_bot, 1);
    step();
    md_resultRDY = 0;
    #1;
    check_eq("done_grant_bot", grant_bot, 0);
    check_eq("done_stall_bot", stall_bot, 1);
    check_eq("top_wb_valid", wb_valid, 1);
    check_eq("top_wb_lane", wb_lane, 0);
    check_eq("top_wb_data", wb_data, 15);
    check_eq("top_wb_rd", wb_rd, 7);
    step();
    #1;
    check_eq("bot_grant", grant_bot, 1);
    check_eq("bot_stall_clear", stall_bot, 0);
    step();
    req_bot = 0;
    #1;
    check_eq("bot_div_pulse", md_ctrl_div, 1);
    check_eq("bot_operandA", md_operandA, 20);
    step();
    md_resultRDY = 1; md_result = 32'd5;
    step();
    md_resultRDY = 0;
    #1;
    check_eq("bot_wb_valid", wb_valid, 1);
    check_eq("bot_wb_lane", wb_lane, 1);
    check_eq("bot_wb_rd", wb_rd, 9);
    check_eq("bot_wb_data", wb_data, 5);
    step();

    // Exceptions: div -> r30/5, mult -> r30/4
    run_op(1'b1, 1'b1, 32'd8, 32'd2, 5'd4, 3, 32'd4, 1'b1, 5'd30, 32'd5);
    run_op(1'b0, 1'b0, 32'hffff_ffff, 32'd2, 5'd6, 2, 32'd0, 1'b1, 5'd30, 32'd4);

    // Timeout on a mult: forced exception after MAX_WAIT wait cycles
    run_op(1'b0, 1'b0, 32'd2, 32'd3, 5'd8, 0, 32'd0, 1'b0, 5'd30, 32'd4);

    // rd = 0 still produces a writeback
    run_op(1'b1, 1'b0, 32'd4, 32'd4, 5'd0, 1, 32'd16, 1'b0, 5'd0, 32'd16);

    // flush in IDLE blocks the grant
    req_top = 1; op_top = 0; opA_top = 1; opB_top = 1; rd_top = 2; flush = 1;
    #1;
    check_eq("flush_idle_nogrant", grant_top, 0);
    check_eq("flush_idle_stall", stall_top, 1);
    step();
    flush = 0;
    #1;
    check_eq("flush_idle_stays_idle", busy, 0);
    check_eq("flush_idle_then_grant", grant_top, 1);
    step();
    req_top = 0;
    step();
    flush = 1;   // WAIT cycle 1
    step();
    flush = 0;
    md_resultRDY = 1; md_result = 32'd1;
    step();
    md_resultRDY = 0;
    #1;
    check_eq("killed_done_busy", busy, 1);
    check_eq("killed_no_wb", wb_valid, 0);
    step();
    #1;
    check_eq("killed_back_idle", busy, 0);
    run_op(1'b0, 1'b1, 32'd100, 32'd7, 5'd11, 4, 32'd14, 1'b0, 5'd11, 32'd14);

    // Reset asserted mid-WAIT takes effect without a clock edge
    req_top = 1; op_top = 0; opA_top = 9; opB_top = 9; rd_top = 12;
    step();
    req_top = 0;
    step();
    step();
    md_resultRDY = 1; md_result = 32'd81;
    #1;
    check_eq("pre_reset_busy", busy, 1);
    reset = 0;
    #1;
    check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_wb_valid", wb_valid, 0);
    check_eq("async_rst_ctrl", {md_ctrl_mult, md_ctrl_div}, 0);
    check_eq("async_rst_operandA", md_operandA, 0);
    step();
    md_resultRDY = 0;
    reset = 1;
    step();
    #1;
    check_eq("post_rst_no_wb", wb_valid, 0);

    // div 9/0
    req_bot = 1; op_bot = 1; opA_bot = 9; opB_bot = 0; rd_bot = 13;
    #1;
    check_eq("div0_grant", grant_bot, 1);
    step();
    req_bot = 0;
    #1;
`ifdef MULTDIV_FASTPATH_EN
    check_eq("fast_no_div_pulse", md_ctrl_div, 0);
    check_eq("fast_wb_valid", wb_valid, 1);
    check_eq("fast_wb_rd", wb_rd, 30);
    check_eq("fast_wb_data", wb_data, 5);
    step();
    #1;
    check_eq("fast_idle", busy, 0);
`else
    check_eq("slow_div_pulse", md_ctrl_div, 1);
    check_eq("slow_no_wb", wb_valid, 0);
    step();
    md_resultRDY = 1; md_result = 0; md_exception = 1;
    step();
    md_resultRDY = 0; md_exception = 0;
    #1;
    check_eq("slow_wb_rd", wb_rd, 30);
    check_eq("slow_wb_data", wb_data, 5);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
